// File: rtl/mb_interface_pkg.sv
// Shared constants for the calculator front end: key ASCII codes, LCD commands,
// the LCD writer state type and the key-to-ASCII decoder.
package mb_interface_pkg;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_MUL   = 8'h2A;
  localparam logic [7:0] ASC_DIV   = 8'h2F;
  localparam logic [7:0] ASC_LPAR  = 8'h28;
  localparam logic [7:0] ASC_RPAR  = 8'h29;
  localparam logic [7:0] ASC_EQ    = 8'h3D;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    WR_INIT,
    WR_IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_WAIT
  } wr_state_t;

  // key = {num[9:0], dot, equal, oper[3:0]}, assumed one-hot; returns {valid, ascii}
  function automatic logic [8:0] key_to_ascii(input logic [15:0] key, input logic shift);
    logic [8:0] r;
    r = '0;
    if (!shift) begin
      for (int i = 1; i < 10; i++)
        if (key[6+i]) r = {1'b1, ASC_0 + 8'(10 - i)};
      if (key[6]) r = {1'b1, ASC_0};
      if (key[5]) r = {1'b1, ASC_DOT};
      if (key[4]) r = {1'b1, ASC_EQ};
      if (key[3]) r = {1'b1, ASC_PLUS};
      if (key[2]) r = {1'b1, ASC_MINUS};
      if (key[1]) r = {1'b1, ASC_MUL};
      if (key[0]) r = {1'b1, ASC_DIV};
    end else begin
      if (key[3]) r = {1'b1, ASC_LPAR};
      if (key[2]) r = {1'b1, ASC_RPAR};
    end
    return r;
  endfunction

endpackage

// File: rtl/mb_interface_lcd_writer.sv
// HD44780 8-bit bus writer: power-up init sequence, then one command or data
// byte per request, with automatic line-2 jump and cursor position tracking.
module lcd_writer
  import mb_interface_pkg::*;
#(
  parameter int E_CYCLES = 2,
  parameter int CMD_WAIT = 40,
  parameter int CLR_WAIT = 1640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       i_cmd_or_data,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_lcd_e,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  wr_state_t   r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic        r_rs, w_rs_next;
  logic [7:0]  r_data, w_data_next;
  logic [1:0]  r_idx, w_idx_next;
  logic        r_init_done, w_init_done_next;
  logic [5:0]  r_pos, w_pos_next;
  logic [7:0]  r_hold, w_hold_next;
  logic        r_hold_valid, w_hold_valid_next;
  logic [7:0]  w_init_cmd;

  always_comb begin
    case (r_idx)
      2'd0:    w_init_cmd = CMD_FUNC_SET;
      2'd1:    w_init_cmd = CMD_DISP_ON;
      2'd2:    w_init_cmd = CMD_ENTRY;
      default: w_init_cmd = CMD_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WR_INIT;
      r_cnt        <= '0;
      r_rs         <= 1'b0;
      r_data       <= '0;
      r_idx        <= '0;
      r_init_done  <= 1'b0;
      r_pos        <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_rs         <= w_rs_next;
      r_data       <= w_data_next;
      r_idx        <= w_idx_next;
      r_init_done  <= w_init_done_next;
      r_pos        <= w_pos_next;
      r_hold       <= w_hold_next;
      r_hold_valid <= w_hold_valid_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_rs_next         = r_rs;
    w_data_next       = r_data;
    w_idx_next        = r_idx;
    w_init_done_next  = r_init_done;
    w_pos_next        = r_pos;
    w_hold_next       = r_hold;
    w_hold_valid_next = r_hold_valid;
    case (r_state)
      WR_INIT: begin
        w_rs_next    = 1'b0;
        w_data_next  = w_init_cmd;
        w_state_next = WR_SETUP;
      end
      WR_IDLE: begin
        if (i_req) begin
          if (!i_cmd_or_data) begin
            w_rs_next    = 1'b0;
            w_data_next  = i_byte;
            w_state_next = WR_SETUP;
            if (i_byte == CMD_CLEAR) w_pos_next = '0;
          end else if (r_pos != 6'd32) begin
            w_pos_next   = r_pos + 6'd1;
            w_state_next = WR_SETUP;
            // first character of line 2: move the cursor, park the data byte
            if (r_pos == 6'd16) begin
              w_hold_next       = i_byte;
              w_hold_valid_next = 1'b1;
              w_rs_next         = 1'b0;
              w_data_next       = CMD_LINE2;
            end else begin
              w_rs_next   = 1'b1;
              w_data_next = i_byte;
            end
          end
        end
      end
      WR_SETUP: begin
        w_state_next = WR_STROBE;
        w_cnt_next   = 16'(E_CYCLES - 1);
      end
      WR_STROBE: begin
        if (r_cnt == '0) begin
          w_state_next = WR_WAIT;
          w_cnt_next   = (!r_rs && r_data == CMD_CLEAR) ? 16'(CLR_WAIT) : 16'(CMD_WAIT);
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      WR_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 16'd1;
        end else if (!r_init_done) begin
          if (r_idx == 2'd3) begin
            w_init_done_next = 1'b1;
            w_state_next     = WR_IDLE;
          end else begin
            w_idx_next   = r_idx + 2'd1;
            w_state_next = WR_INIT;
          end
        end else if (r_hold_valid) begin
          w_hold_valid_next = 1'b0;
          w_rs_next         = 1'b1;
          w_data_next       = r_hold;
          w_state_next      = WR_SETUP;
        end else begin
          w_state_next = WR_IDLE;
        end
      end
      default: w_state_next = WR_INIT;
    endcase
  end

  assign o_busy     = (r_state != WR_IDLE);
  assign o_lcd_e    = (r_state == WR_STROBE);
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = r_data;

endmodule

// File: rtl/mb_interface.sv
// Calculator front end: debounced one-hot keypad capture, 32-character
// expression buffer and LCD echo through a single pending-character slot.
module mb_interface
  import mb_interface_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int E_CYCLES      = 2,
  parameter int CMD_WAIT      = 40,
  parameter int CLR_WAIT      = 1640
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] BUTTON_NUM_IN,
  input  logic       BUTTON_DOT_IN,
  input  logic       BUTTON_EQUAL_IN,
  input  logic [3:0] BUTTON_OPER_IN,
  input  logic       SHIFT_IN,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic       EXPR_READY,
  output logic [5:0] EXPR_LEN,
  input  logic [4:0] EXPR_RADDR,
  output logic [7:0] EXPR_RDATA,
  input  logic       EXPR_ACK
);

  logic [16:0] r_sync1, r_sync2;
  logic [15:0] r_prev;
  logic [7:0]  r_cnt;
  logic        r_armed, r_init_seen, r_ready;
  logic [5:0]  r_len;
  logic        r_pend_valid, r_pend_rs;
  logic [7:0]  r_pend_byte;
  logic [7:0]  r_buf [32];

  logic [15:0] w_key;
  logic        w_shift, w_hit, w_accept, w_busy, w_clear, w_take_eq, w_store;
  logic [8:0]  w_code;

  assign w_key   = r_sync2[15:0];
  assign w_shift = r_sync2[16];
  assign w_code  = key_to_ascii(w_key, w_shift);

  // w_hit marks the edge where the current pattern completes STABLE_CYCLES cycles
  assign w_hit    = (w_key == r_prev) ? (r_cnt == 8'(STABLE_CYCLES - 1)) : (STABLE_CYCLES == 1);
  assign w_accept = w_hit && r_armed && r_init_seen && !r_ready && $onehot(w_key) && w_code[8];
  assign w_clear  = EXPR_ACK && r_ready;
  assign w_take_eq = !w_clear && w_accept && !r_pend_valid && w_code[7:0] == ASC_EQ && r_len != 6'd0;
  assign w_store  = !w_clear && w_accept && !r_pend_valid && w_code[7:0] != ASC_EQ && r_len != 6'd32;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_prev       <= '0;
      r_cnt        <= '0;
      r_armed      <= 1'b0;
      r_init_seen  <= 1'b0;
      r_ready      <= 1'b0;
      r_len        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_rs    <= 1'b0;
      r_pend_byte  <= '0;
    end else begin
      r_sync1 <= {SHIFT_IN, BUTTON_NUM_IN, BUTTON_DOT_IN, BUTTON_EQUAL_IN, BUTTON_OPER_IN};
      r_sync2 <= r_sync1;
      if (w_key != r_prev) begin
        r_prev <= w_key;
        r_cnt  <= 8'd1;
      end else if (r_cnt < 8'(STABLE_CYCLES)) begin
        r_cnt <= r_cnt + 8'd1;
      end
      // any stable non-zero pattern, valid or not, must be released before the next key
      if (w_hit) r_armed <= (w_key == '0);
      if (!w_busy) r_init_seen <= 1'b1;
      if (r_pend_valid && !w_busy) r_pend_valid <= 1'b0;
      if (w_clear) begin
        r_len        <= '0;
        r_ready      <= 1'b0;
        r_pend_valid <= 1'b1;
        r_pend_rs    <= 1'b0;
        r_pend_byte  <= CMD_CLEAR;
      end else if (w_take_eq || w_store) begin
        r_pend_valid <= 1'b1;
        r_pend_rs    <= 1'b1;
        r_pend_byte  <= w_code[7:0];
        if (w_take_eq) r_ready <= 1'b1;
        else           r_len   <= r_len + 6'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_store) r_buf[r_len[4:0]] <= w_code[7:0];
  end

  lcd_writer #(
    .E_CYCLES (E_CYCLES),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT)
  ) u_lcd_writer (
    .clk           (CLK),
    .rst           (RST),
    .i_req         (r_pend_valid),
    .i_cmd_or_data (r_pend_rs),
    .i_byte        (r_pend_byte),
    .o_busy        (w_busy),
    .o_lcd_e       (LCD_E),
    .o_lcd_rs      (LCD_RS),
    .o_lcd_rw      (LCD_RW),
    .o_lcd_data    (LCD_DATA)
  );

  assign EXPR_READY = r_ready;
  assign EXPR_LEN   = r_len;
  assign EXPR_RDATA = r_buf[EXPR_RADDR];

endmodule

// File: tb/tb_mb_interface.sv
// Directed bench for mb_interface: LCD bus monitor plus a linear sequence of
// key presses with hand-computed buffer, length and LCD byte expectations.
module tb_mb_interface;

  localparam int SC  = 4;
  localparam int EC  = 2;
  localparam int CW  = 5;
  localparam int CLW = 20;

  logic       CLK = 1'b0;
  logic       RST;
  logic [9:0] BUTTON_NUM_IN;
  logic       BUTTON_DOT_IN, BUTTON_EQUAL_IN, SHIFT_IN, EXPR_ACK;
  logic [3:0] BUTTON_OPER_IN;
  logic       LCD_E, LCD_RS, LCD_RW, EXPR_READY;
  logic [7:0] LCD_DATA, EXPR_RDATA;
  logic [5:0] EXPR_LEN;
  logic [4:0] EXPR_RADDR;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] lcd_q[$];
  logic       e_prev = 1'b0;
  int         e_len = 0;
  logic [8:0] bus_prev = '0;

  mb_interface #(.STABLE_CYCLES(SC), .E_CYCLES(EC), .CMD_WAIT(CW), .CLR_WAIT(CLW)) dut (
    .CLK(CLK), .RST(RST),
    .BUTTON_NUM_IN(BUTTON_NUM_IN), .BUTTON_DOT_IN(BUTTON_DOT_IN),
    .BUTTON_EQUAL_IN(BUTTON_EQUAL_IN), .BUTTON_OPER_IN(BUTTON_OPER_IN),
    .SHIFT_IN(SHIFT_IN),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA),
    .EXPR_READY(EXPR_READY), .EXPR_LEN(EXPR_LEN),
    .EXPR_RADDR(EXPR_RADDR), .EXPR_RDATA(EXPR_RDATA), .EXPR_ACK(EXPR_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // LCD bus monitor: record each transfer at E rise, check setup, hold and E width
  always @(negedge CLK) begin
    if (!RST) begin
      if (LCD_E && !e_prev) begin
        lcd_q.push_back({LCD_RS, LCD_DATA});
        check("lcd_setup", {LCD_RS, LCD_DATA}, bus_prev);
        e_len = 1;
      end else if (LCD_E) begin
        e_len++;
      end else if (e_prev) begin
        check("lcd_e_width", e_len, EC);
        check("lcd_hold", {LCD_RS, LCD_DATA}, bus_prev);
      end
    end
    e_prev   = LCD_E;
    bus_prev = {LCD_RS, LCD_DATA};
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [9:0] num, input logic dot, input logic eq,
                       input logic [3:0] op, input logic sh);
    BUTTON_NUM_IN = num; BUTTON_DOT_IN = dot; BUTTON_EQUAL_IN = eq;
    BUTTON_OPER_IN = op; SHIFT_IN = sh;
    cyc(15);
    BUTTON_NUM_IN = '0; BUTTON_DOT_IN = 1'b0; BUTTON_EQUAL_IN = 1'b0;
    BUTTON_OPER_IN = '0; SHIFT_IN = 1'b0;
    cyc(15);
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [7:0] exp);
    EXPR_RADDR = addr;
    #1;
    check(tag, EXPR_RDATA, exp);
  endtask

  task automatic q_at(input string tag, input int idx, input logic [8:0] exp);
    if (idx < lcd_q.size()) check(tag, lcd_q[idx], exp);
    else check(tag, 32'hDEAD, exp);
  endtask

  initial begin
    logic [9:0] v;
    BUTTON_NUM_IN = '0; BUTTON_DOT_IN = 1'b0; BUTTON_EQUAL_IN = 1'b0;
    BUTTON_OPER_IN = '0; SHIFT_IN = 1'b0; EXPR_ACK = 1'b0; EXPR_RADDR = '0;
    RST = 1'b1;
    cyc(3);
    check("rst_lcd_e", LCD_E, 1'b0);
    check("rst_lcd_rs", LCD_RS, 1'b0);
    check("rst_lcd_rw", LCD_RW, 1'b0);
    check("rst_lcd_data", LCD_DATA, 8'h00);
    check("rst_ready", EXPR_READY, 1'b0);
    check("rst_len", EXPR_LEN, 6'd0);
    RST = 1'b0;

    // init sequence
    for (int i = 0; i < 300 && lcd_q.size() < 4; i++) cyc(1);
    check("init_count", lcd_q.size(), 4);
    q_at("init0", 0, 9'h038);
    q_at("init1", 1, 9'h00C);
    q_at("init2", 2, 9'h006);
    q_at("init3", 3, 9'h001);
    cyc(40);
    lcd_q.delete();

    // key '2' with latency check: EXPR_LEN moves at edge 2+SC after the change
    BUTTON_NUM_IN = 10'b01_0000_0000;
    cyc(5);
    check("lat_before", EXPR_LEN, 6'd0);
    cyc(1);
    check("lat_after", EXPR_LEN, 6'd1);
    cyc(9);
    BUTTON_NUM_IN = '0;
    cyc(15);
    press(10'b00_0100_0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    press(10'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    press(10'b00_1000_0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("len4", EXPR_LEN, 6'd4);
    rd("buf0", 5'd0, 8'h32);
    rd("buf1", 5'd1, 8'h34);
    rd("buf2", 5'd2, 8'h2E);
    rd("buf3", 5'd3, 8'h33);
    check("lcd_p1_count", lcd_q.size(), 4);
    q_at("lcd_p1_0", 0, 9'h132);
    q_at("lcd_p1_1", 1, 9'h134);
    q_at("lcd_p1_2", 2, 9'h12E);
    q_at("lcd_p1_3", 3, 9'h133);
    lcd_q.delete();

    // shifted and plain operators, then invalid combinations
    press(10'b0, 1'b0, 1'b0, 4'b1000, 1'b1);
    press(10'b0, 1'b0, 1'b0, 4'b0100, 1'b1);
    press(10'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    press(10'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    press(10'b10_0000_0000, 1'b0, 1'b0, 4'b0000, 1'b1);
    press(10'b11_0000_0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    press(10'b0, 1'b0, 1'b0, 4'b0010, 1'b1);
    check("len8", EXPR_LEN, 6'd8);
    rd("buf4", 5'd4, 8'h28);
    rd("buf5", 5'd5, 8'h29);
    rd("buf6", 5'd6, 8'h2B);
    rd("buf7", 5'd7, 8'h2D);
    check("lcd_p2_count", lcd_q.size(), 4);
    q_at("lcd_p2_0", 0, 9'h128);
    q_at("lcd_p2_3", 3, 9'h12D);
    lcd_q.delete();

    // digits 1..9: the ninth lands on position 16 and needs 0xC0 first
    for (int d = 1; d <= 9; d++) begin
      v = 10'b1 << (10 - d);
      press(v, 1'b0, 1'b0, 4'b0000, 1'b0);
    end
    check("len17", EXPR_LEN, 6'd17);
    rd("buf8", 5'd8, 8'h31);
    rd("buf16", 5'd16, 8'h39);
    check("lcd_p3_count", lcd_q.size(), 10);
    q_at("lcd_p3_7", 7, 9'h138);
    q_at("lcd_p3_line2", 8, 9'h0C0);
    q_at("lcd_p3_9", 9, 9'h139);
    lcd_q.delete();

    // ACK without a ready expression is ignored
    EXPR_ACK = 1'b1; cyc(1); EXPR_ACK = 1'b0; cyc(2);
    check("ack_idle_len", EXPR_LEN, 6'd17);

    // '=' freezes the buffer, later keys ignored
    press(10'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    check("eq_ready", EXPR_READY, 1'b1);
    check("eq_len", EXPR_LEN, 6'd17);
    check("eq_lcd_count", lcd_q.size(), 1);
    q_at("eq_lcd", 0, 9'h13D);
    lcd_q.delete();
    press(10'b00_0010_0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("frozen_len", EXPR_LEN, 6'd17);
    check("frozen_lcd", lcd_q.size(), 0);

    EXPR_ACK = 1'b1; cyc(1); EXPR_ACK = 1'b0;
    check("ack_len", EXPR_LEN, 6'd0);
    check("ack_ready", EXPR_READY, 1'b0);
    cyc(40);
    check("ack_lcd_count", lcd_q.size(), 1);
    q_at("ack_lcd", 0, 9'h001);
    lcd_q.delete();

    // '=' on an empty expression is ignored
    press(10'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    check("eq_empty_ready", EXPR_READY, 1'b0);
    check("eq_empty_lcd", lcd_q.size(), 0);

    // fill all 32 entries, then a 33rd key and a hidden '='
    for (int k = 0; k < 32; k++) press(10'b00_0000_0001, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("len32", EXPR_LEN, 6'd32);
    rd("buf31", 5'd31, 8'h30);
    press(10'b00_0000_1000, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("full_len", EXPR_LEN, 6'd32);
    rd("full_buf31", 5'd31, 8'h30);
    check("lcd_p4_count", lcd_q.size(), 33);
    q_at("lcd_p4_line2", 16, 9'h0C0);
    q_at("lcd_p4_last", 32, 9'h130);
    lcd_q.delete();
    press(10'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    check("full_eq_ready", EXPR_READY, 1'b1);
    check("full_eq_lcd", lcd_q.size(), 0);
    EXPR_ACK = 1'b1; cyc(1); EXPR_ACK = 1'b0;
    check("full_ack_len", EXPR_LEN, 6'd0);
    cyc(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
